slave_receiver: RTL and testbench
=================================

Name: slave_receiver

Overview:
Receive-side counterpart of the multi-protocol master transmitter. It deserializes SPI (slave, modes 0–3) or UART (8N1) traffic into a parallel byte with a one-cycle valid strobe, selected by prot_sel. It runs on a single free-running clock with per-protocol enables; there is no clock gating. The I2C slave is out of scope; prot_sel 00 and 10 park both engines.

Parameters:
CLKS_PER_BIT, 16, system clocks per UART bit; must be even and ≥ 4.
SYNC_STAGES, 2, synchronizer flops on each asynchronous serial input.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset
prot_sel  input  2  00 idle, 01 SPI, 10 idle (I2C not handled), 11 UART
spi_mode  input  2  [1]=CPOL, [0]=CPHA
sclk  input  1  SPI clock from master, asynchronous
cs  input  1  SPI chip select, active-low, asynchronous
s_dat_spi  input  1  SPI serial data (MOSI), MSB first
s_dat_uart  input  1  UART serial line, idle high, LSB first
p_dat_out  output  8  last received byte
dat_valid  output  1  one-cycle pulse when p_dat_out updates
frame_err  output  1  one-cycle pulse on UART stop-bit error
rx_busy  output  1  high while the active engine is mid-byte or mid-frame
srdone  output  1  sticky done flag; set with dat_valid, cleared when a new byte or frame starts

Behaviour:
- Reset (rst=0 at a clk edge):
  - p_dat_out=0, dat_valid=0, frame_err=0, rx_busy=0, srdone=0.
  - Synchronizers preset: sclk=CPOL, cs=1, uart=1.
  - Engines return to IDLE with bit counters at 0.
- Synchronizers: every serial input passes through SYNC_STAGES flops. Edge detection compares the last two synchronized samples.
- prot_sel change (any cycle): both engines abort to IDLE, discard partial data, no dat_valid, no frame_err.
- SPI engine (prot_sel=01):
  - Synced cs high: bit counter held at 0, rx_busy=0.
  - Sample edge: leading edge of sclk when CPHA=0, trailing edge when CPHA=1. Leading edge is rising when CPOL=0, falling when CPOL=1.
  - On each sample edge with cs low: shift s_dat_spi into bit 0 of the shift register (MSB-first) and increment the counter. rx_busy=1 from the first sample.
  - 8th sample: next cycle p_dat_out=shift register, dat_valid=1 for one cycle, srdone=1, counter wraps to 0.
  - cs still low after the 8th sample: reception continues with the next byte, no gap required.
  - cs rising with counter 1–7: partial byte discarded, no dat_valid, counter=0.
  - Simultaneous cs rise and 8th sample edge in the same synced cycle: the byte completes and is reported.
- UART engine (prot_sel=11). States are IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a synced line falling edge goes to START, counter=0, rx_busy=1, srdone=0.
  - START: at count CLKS_PER_BIT/2−1, line still low goes to DATA; line high (glitch) returns to IDLE with no outputs.
  - DATA: sample every CLKS_PER_BIT clocks, LSB first. After 8 bits go to STOP.
  - STOP: sample after CLKS_PER_BIT clocks.
    - Line 1: next cycle p_dat_out updated, dat_valid pulses, srdone=1, return to IDLE.
    - Line 0: frame_err pulses, p_dat_out unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until synced line=1, then IDLE.
  - rx_busy=0 only in IDLE.
- Latency:
  - SPI: dat_valid is SYNC_STAGES+2 clk after the 8th raw sample edge.
  - UART: dat_valid is SYNC_STAGES + 9.5·CLKS_PER_BIT + 1 clk (±1) after the raw start-bit falling edge.
- dat_valid and frame_err never assert in the same cycle. p_dat_out holds its value between valids.

Test Plan:
- SPI mode 0, cs low, master shifts 0xA5 MSB-first with sclk period 8 clk → one dat_valid, p_dat_out=0xA5, srdone=1, rx_busy back to 0 after cs rises.
- SPI mode 3, back-to-back 0x3C then 0xC3 under one cs assertion → two dat_valid pulses with values 0x3C and 0xC3. Repeat in modes 1 and 2 → same values.
- SPI cs deasserted after 5 bits, then full byte 0x81 → no valid for the partial byte; single valid with 0x81.
- UART CLKS_PER_BIT=16, frame 0x55 then 0xF0 → two valids with 0x55 and 0xF0, frame_err never asserted; low glitch of 6 clk on an idle line → no activity, rx_busy returns to 0.
- UART frame 0x33 with stop bit 0 → frame_err one pulse, no dat_valid, p_dat_out keeps previous value. Line held low 40 clk then high, then frame 0x12 → valid with 0x12.
- rst low mid-UART-frame, and separately prot_sel 11→01 mid-frame → all outputs 0 (reset case) or abort without valid (prot_sel case). Next SPI byte 0x7E received correctly.

Source files
------------

// File: rtl/slave_receiver.sv
// Receive-side SPI slave / UART 8N1 deserializer. Produces one parallel byte
// per completed transfer with a single-cycle valid strobe.
module slave_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] prot_sel,
    input  logic [1:0] spi_mode,
    input  logic       sclk,
    input  logic       cs,
    input  logic       s_dat_spi,
    input  logic       s_dat_uart,
    output logic [7:0] p_dat_out,
    output logic       dat_valid,
    output logic       frame_err,
    output logic       rx_busy,
    output logic       srdone
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP,
        U_WAIT_HIGH
    } uartState_t;

    logic [SYNC_STAGES-1:0] r_sclkSync;
    logic [SYNC_STAGES-1:0] r_csSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic [SYNC_STAGES-1:0] r_uartSync;
    logic                   r_sclkPrev;
    logic                   r_csPrev;
    logic                   r_uartPrev;
    logic [1:0]             r_protPrev;

    logic [2:0]  r_spiCnt;
    logic [7:0]  r_spiShift;
    logic        r_spiFull;

    uartState_t  r_uState;
    uartState_t  w_uStateNext;
    logic [CW-1:0] r_uCnt;
    logic [CW-1:0] w_uCntNext;
    logic [2:0]  r_uBitIdx;
    logic [2:0]  w_uBitIdxNext;
    logic [7:0]  r_uShift;
    logic [7:0]  w_uShiftNext;
    logic        w_uDone;
    logic        w_uErr;
    logic        w_uStart;

    logic w_sclk, w_cs, w_mosi, w_uart;
    logic w_sclkRise, w_sclkFall, w_leadEdge, w_trailEdge, w_sampleEdge;
    logic w_csRise, w_uartFall, w_protChange, w_spiEn, w_uartEn;
    logic w_spiSample, w_spiLastBit, w_spiFirstBit;

    // Edges are judged between the synchronizer output and one extra history flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sclkSync <= {SYNC_STAGES{spi_mode[1]}};
            r_csSync   <= '1;
            r_mosiSync <= '0;
            r_uartSync <= '1;
            r_sclkPrev <= spi_mode[1];
            r_csPrev   <= 1'b1;
            r_uartPrev <= 1'b1;
            r_protPrev <= prot_sel;
        end else begin
            r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], sclk};
            r_csSync   <= {r_csSync[SYNC_STAGES-2:0], cs};
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], s_dat_spi};
            r_uartSync <= {r_uartSync[SYNC_STAGES-2:0], s_dat_uart};
            r_sclkPrev <= r_sclkSync[SYNC_STAGES-1];
            r_csPrev   <= r_csSync[SYNC_STAGES-1];
            r_uartPrev <= r_uartSync[SYNC_STAGES-1];
            r_protPrev <= prot_sel;
        end
    end

    assign w_sclk        = r_sclkSync[SYNC_STAGES-1];
    assign w_cs          = r_csSync[SYNC_STAGES-1];
    assign w_mosi        = r_mosiSync[SYNC_STAGES-1];
    assign w_uart        = r_uartSync[SYNC_STAGES-1];
    assign w_sclkRise    = w_sclk & ~r_sclkPrev;
    assign w_sclkFall    = ~w_sclk & r_sclkPrev;
    assign w_leadEdge    = spi_mode[1] ? w_sclkFall : w_sclkRise;
    assign w_trailEdge   = spi_mode[1] ? w_sclkRise : w_sclkFall;
    assign w_sampleEdge  = spi_mode[0] ? w_trailEdge : w_leadEdge;
    assign w_csRise      = w_cs & ~r_csPrev;
    assign w_uartFall    = ~w_uart & r_uartPrev;
    assign w_protChange  = (prot_sel != r_protPrev);
    assign w_spiEn       = (prot_sel == 2'b01) && !w_protChange;
    assign w_uartEn      = (prot_sel == 2'b11) && !w_protChange;

    // A sample coinciding with cs rising still counts so a final bit is not lost.
    assign w_spiSample   = w_spiEn && w_sampleEdge && (!w_cs || w_csRise);
    assign w_spiLastBit  = w_spiSample && (r_spiCnt == 3'd7);
    assign w_spiFirstBit = w_spiSample && (r_spiCnt == 3'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_spiCnt   <= 3'd0;
            r_spiShift <= 8'h00;
            r_spiFull  <= 1'b0;
        end else if (!w_spiEn) begin
            r_spiCnt  <= 3'd0;
            r_spiFull <= 1'b0;
        end else begin
            r_spiFull <= w_spiLastBit;
            if (w_spiSample) begin
                r_spiShift <= {r_spiShift[6:0], w_mosi};
                r_spiCnt   <= r_spiCnt + 3'd1;
            end else if (w_cs) begin
                r_spiCnt <= 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_uState  <= U_IDLE;
            r_uCnt    <= '0;
            r_uBitIdx <= 3'd0;
            r_uShift  <= 8'h00;
        end else begin
            r_uState  <= w_uStateNext;
            r_uCnt    <= w_uCntNext;
            r_uBitIdx <= w_uBitIdxNext;
            r_uShift  <= w_uShiftNext;
        end
    end

    always_comb begin
        w_uStateNext  = r_uState;
        w_uCntNext    = r_uCnt;
        w_uBitIdxNext = r_uBitIdx;
        w_uShiftNext  = r_uShift;
        w_uDone       = 1'b0;
        w_uErr        = 1'b0;
        w_uStart      = 1'b0;
        if (!w_uartEn) begin
            w_uStateNext  = U_IDLE;
            w_uCntNext    = '0;
            w_uBitIdxNext = 3'd0;
        end else begin
            case (r_uState)
                U_IDLE: begin
                    if (w_uartFall) begin
                        w_uStateNext = U_START;
                        w_uCntNext   = '0;
                        w_uStart     = 1'b1;
                    end
                end
                U_START: begin
                    // Mid-start-bit check rejects short low glitches.
                    if (r_uCnt == HALF_LAST) begin
                        w_uCntNext    = '0;
                        w_uBitIdxNext = 3'd0;
                        w_uStateNext  = w_uart ? U_IDLE : U_DATA;
                    end else begin
                        w_uCntNext = r_uCnt + CW'(1);
                    end
                end
                U_DATA: begin
                    if (r_uCnt == BIT_LAST) begin
                        w_uCntNext   = '0;
                        w_uShiftNext = {w_uart, r_uShift[7:1]};
                        if (r_uBitIdx == 3'd7) begin
                            w_uStateNext = U_STOP;
                        end else begin
                            w_uBitIdxNext = r_uBitIdx + 3'd1;
                        end
                    end else begin
                        w_uCntNext = r_uCnt + CW'(1);
                    end
                end
                U_STOP: begin
                    if (r_uCnt == BIT_LAST) begin
                        w_uCntNext = '0;
                        if (w_uart) begin
                            w_uDone      = 1'b1;
                            w_uStateNext = U_IDLE;
                        end else begin
                            w_uErr       = 1'b1;
                            w_uStateNext = U_WAIT_HIGH;
                        end
                    end else begin
                        w_uCntNext = r_uCnt + CW'(1);
                    end
                end
                U_WAIT_HIGH: begin
                    if (w_uart) begin
                        w_uStateNext = U_IDLE;
                    end
                end
                default: begin
                    w_uStateNext = U_IDLE;
                end
            endcase
        end
    end

    // Engines are mutually exclusive, so at most one completion arrives per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            p_dat_out <= 8'h00;
            dat_valid <= 1'b0;
            frame_err <= 1'b0;
            srdone    <= 1'b0;
        end else begin
            dat_valid <= 1'b0;
            frame_err <= w_uErr;
            if (r_spiFull) begin
                p_dat_out <= r_spiShift;
                dat_valid <= 1'b1;
                srdone    <= 1'b1;
            end else if (w_uDone) begin
                p_dat_out <= r_uShift;
                dat_valid <= 1'b1;
                srdone    <= 1'b1;
            end else if (w_spiFirstBit || w_uStart) begin
                srdone <= 1'b0;
            end
        end
    end

    assign rx_busy = (r_spiCnt != 3'd0) || (r_uState != U_IDLE);

endmodule

// File: tb/tb_slave_receiver.sv
// Scoreboard bench for slave_receiver: stimulus tasks push expected events,
// a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_slave_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] prot_sel = 2'b01;
    logic [1:0] spi_mode = 2'b00;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       s_dat_spi = 1'b0;
    logic       s_dat_uart = 1'b1;
    logic [7:0] p_dat_out;
    logic       dat_valid;
    logic       frame_err;
    logic       rx_busy;
    logic       srdone;

    slave_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .prot_sel(prot_sel), .spi_mode(spi_mode),
        .sclk(sclk), .cs(cs), .s_dat_spi(s_dat_spi), .s_dat_uart(s_dat_uart),
        .p_dat_out(p_dat_out), .dat_valid(dat_valid), .frame_err(frame_err),
        .rx_busy(rx_busy), .srdone(srdone)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         isErr;
        logic [7:0] data;
    } expEvent_t;

    expEvent_t  expQ[$];
    logic [7:0] lastByte = 8'h00;
    int         checkCount = 0;
    int         passCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a full byte (8 bits under cs, or a UART frame with a high
    // stop bit) yields that byte; a low stop bit yields an error with the old byte held.
    task automatic expectByte(input logic [7:0] b);
        expEvent_t e;
        e.isErr = 1'b0;
        e.data  = b;
        expQ.push_back(e);
        lastByte = b;
    endtask

    task automatic expectErr();
        expEvent_t e;
        e.isErr = 1'b1;
        e.data  = lastByte;
        expQ.push_back(e);
    endtask

    // Monitor: every output strobe consumes one scoreboard entry.
    always @(negedge clk) begin
        expEvent_t e;
        if (rst && (dat_valid === 1'b1 || frame_err === 1'b1)) begin
            if (dat_valid && frame_err) begin
                checkOutput("validErrOverlap", 1, 0);
            end else if (expQ.size() == 0) begin
                checkOutput("unexpectedStrobe", {dat_valid, frame_err}, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("eventKind", frame_err, e.isErr);
                if (!e.isErr) begin
                    checkOutput("byte", p_dat_out, e.data);
                    checkOutput("srdoneSet", srdone, 1);
                end else begin
                    checkOutput("heldByte", p_dat_out, e.data);
                end
            end
        end
    end

    task automatic setSpiMode(input logic [1:0] m);
        spi_mode = m;
        sclk = m[1];
        waitClk(10);
    endtask

    task automatic csAssert();
        cs = 1'b0;
        waitClk(4);
    endtask

    task automatic csRelease();
        waitClk(4);
        cs = 1'b1;
        waitClk(8);
        checkOutput("spiIdleAfterCs", rx_busy, 0);
    endtask

    // Master side of SPI: sclk half-period of 4 clk, data changes on the non-sample edge.
    task automatic applyStimulusSpi(input logic [7:0] b, input int nbits);
        if (nbits == 8) expectByte(b);
        for (int i = 0; i < nbits; i++) begin
            if (i == 1) begin
                checkOutput("spiBusyMidByte", rx_busy, 1);
                checkOutput("spiSrdoneCleared", srdone, 0);
            end
            if (!spi_mode[0]) begin
                s_dat_spi = b[7-i];
                waitClk(4);
                sclk = ~spi_mode[1];
                waitClk(4);
                sclk = spi_mode[1];
            end else begin
                sclk = ~spi_mode[1];
                s_dat_spi = b[7-i];
                waitClk(4);
                sclk = spi_mode[1];
                waitClk(4);
            end
        end
    endtask

    task automatic applyStimulusUart(input logic [7:0] b, input logic stopBit, input int holdLow);
        if (stopBit) expectByte(b);
        else expectErr();
        s_dat_uart = 1'b0;
        waitClk(CPB / 2);
        checkOutput("uartBusyInStart", rx_busy, 1);
        checkOutput("uartSrdoneCleared", srdone, 0);
        waitClk(CPB - CPB / 2);
        for (int i = 0; i < 8; i++) begin
            s_dat_uart = b[i];
            waitClk(CPB);
        end
        s_dat_uart = stopBit;
        waitClk(CPB);
        if (!stopBit) begin
            s_dat_uart = 1'b0;
            waitClk(holdLow);
        end
        s_dat_uart = 1'b1;
        waitClk(2 * CPB);
        checkOutput("uartIdleAfterFrame", rx_busy, 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_pdat"}, p_dat_out, 0);
        checkOutput({tag, "_valid"}, dat_valid, 0);
        checkOutput({tag, "_ferr"}, frame_err, 0);
        checkOutput({tag, "_busy"}, rx_busy, 0);
        checkOutput({tag, "_srdone"}, srdone, 0);
    endtask

    initial begin
        logic [1:0] m;
        logic [7:0] b;
        int         nb;

        rst = 1'b0;
        waitClk(3);
        checkResetOutputs("reset");
        rst = 1'b1;
        waitClk(3);

        // SPI mode 0, single byte
        setSpiMode(2'b00);
        csAssert();
        applyStimulusSpi(8'hA5, 8);
        csRelease();
        checkOutput("spiSrdoneSticky", srdone, 1);

        // Back-to-back bytes under one cs in modes 3, 1, 2
        for (int k = 0; k < 3; k++) begin
            m = (k == 0) ? 2'b11 : ((k == 1) ? 2'b01 : 2'b10);
            setSpiMode(m);
            csAssert();
            applyStimulusSpi(8'h3C, 8);
            applyStimulusSpi(8'hC3, 8);
            csRelease();
        end

        // Partial byte discarded, then a full byte
        setSpiMode(2'b00);
        csAssert();
        applyStimulusSpi(8'hFF, 5);
        csRelease();
        csAssert();
        applyStimulusSpi(8'h81, 8);
        csRelease();

        // Randomized SPI traffic
        for (int k = 0; k < 6; k++) begin
            m  = 2'($urandom_range(0, 3));
            nb = $urandom_range(1, 2);
            setSpiMode(m);
            csAssert();
            for (int j = 0; j < nb; j++) begin
                b = 8'($urandom);
                applyStimulusSpi(b, 8);
            end
            csRelease();
        end

        // UART
        prot_sel = 2'b11;
        s_dat_uart = 1'b1;
        waitClk(10);
        applyStimulusUart(8'h55, 1'b1, 0);
        applyStimulusUart(8'hF0, 1'b1, 0);

        s_dat_uart = 1'b0;
        waitClk(5);
        checkOutput("glitchBusy", rx_busy, 1);
        waitClk(1);
        s_dat_uart = 1'b1;
        waitClk(30);
        checkOutput("glitchIdle", rx_busy, 0);

        applyStimulusUart(8'h33, 1'b0, 40);
        checkOutput("heldAfterErr", p_dat_out, lastByte);
        applyStimulusUart(8'h12, 1'b1, 0);

        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            applyStimulusUart(b, ($urandom_range(0, 3) != 0), $urandom_range(10, 40));
        end

        // Reset in the middle of a UART frame
        s_dat_uart = 1'b0;
        waitClk(3 * CPB);
        rst = 1'b0;
        s_dat_uart = 1'b1;
        waitClk(3);
        checkResetOutputs("midReset");
        lastByte = 8'h00;
        rst = 1'b1;
        waitClk(10);

        // Protocol switch in the middle of a UART frame aborts silently
        s_dat_uart = 1'b0;
        waitClk(4 * CPB);
        prot_sel = 2'b01;
        waitClk(2);
        s_dat_uart = 1'b1;
        waitClk(20);
        checkOutput("abortIdle", rx_busy, 0);
        checkOutput("abortHeld", p_dat_out, 0);

        setSpiMode(2'b00);
        csAssert();
        applyStimulusSpi(8'h7E, 8);
        csRelease();

        waitClk(20);
        checkOutput("scoreboardDrained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
